// File: rtl/branch_resolver.sv
// Branch-resolution stage around the external 32-bit comparator: registers one
// branch, samples the comparator, checks the prediction and hands the result to writeback.
module branch_resolver #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_offset,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_op,
    input  logic        in_pred_taken,
    output logic [31:0] cmp_a,
    output logic [31:0] cmp_b,
    output logic [2:0]  cmp_op,
    input  logic        cmp_out,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_taken,
    output logic [31:0] out_target,
    output logic [15:0] mispredict_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;

    logic [31:0] pc_reg;
    logic [31:0] offset_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [2:0]  op_reg;
    logic        pred_reg;

    logic        taken_reg;
    logic [31:0] target_reg;
    logic [3:0]  flush_cnt_reg;
    logic [15:0] mispredict_count_reg;

    logic        accept;
    logic        in_compare;
    logic        mispredict_now;
    logic [31:0] fallthrough_pc;
    logic [31:0] branch_pc;
    logic [31:0] resolved_target;

    assign accept     = (state_reg == ST_IDLE) && in_valid;
    assign in_compare = (state_reg == ST_COMPARE);

    // Both candidate targets are formed from registered operands; cmp_out only selects.
    assign fallthrough_pc  = pc_reg + 32'd4;
    assign branch_pc       = fallthrough_pc + (offset_reg << 2);
    assign resolved_target = cmp_out ? branch_pc : fallthrough_pc;
    assign mispredict_now  = in_compare && (cmp_out != pred_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (in_valid) state_next = ST_COMPARE;
            ST_COMPARE: state_next = ST_RESOLVE;
            ST_RESOLVE: state_next = out_ready ? ST_IDLE : ST_HOLD;
            ST_HOLD:    if (out_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_reg     <= '0;
            offset_reg <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            pred_reg   <= 1'b0;
        end else if (accept) begin
            pc_reg     <= in_pc;
            offset_reg <= in_offset;
            a_reg      <= in_a;
            b_reg      <= in_b;
            op_reg     <= in_op;
            pred_reg   <= in_pred_taken;
        end
    end

    // Result registers only move at the end of COMPARE, so they hold through HOLD.
    always_ff @(posedge clock) begin
        if (!reset) begin
            taken_reg  <= 1'b0;
            target_reg <= '0;
        end else if (in_compare) begin
            taken_reg  <= cmp_out;
            target_reg <= resolved_target;
        end
    end

    // Loaded on the edge entering RESOLVE so flush rises together with redirect_valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            flush_cnt_reg <= '0;
        end else if (mispredict_now) begin
            flush_cnt_reg <= FLUSH_LOAD;
        end else if (flush_cnt_reg != 4'd0) begin
            flush_cnt_reg <= flush_cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mispredict_count_reg <= '0;
        end else if (mispredict_now && (mispredict_count_reg != COUNT_MAX)) begin
            mispredict_count_reg <= mispredict_count_reg + 16'd1;
        end
    end

    // RESOLVE lasts exactly one cycle, which makes the redirect a single pulse.
    assign redirect_valid   = (state_reg == ST_RESOLVE) && (taken_reg != pred_reg);
    assign redirect_pc      = redirect_valid ? target_reg : 32'd0;

    assign in_ready         = (state_reg == ST_IDLE);
    assign out_valid        = (state_reg == ST_RESOLVE) || (state_reg == ST_HOLD);
    assign out_taken        = taken_reg;
    assign out_target       = target_reg;
    assign flush            = (flush_cnt_reg != 4'd0);
    assign mispredict_count = mispredict_count_reg;

    assign cmp_a  = a_reg;
    assign cmp_b  = b_reg;
    assign cmp_op = op_reg;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: behavioural comparator, vector table plus a scoreboard
// queue popped on each writeback handshake, and hand sequences for reset and saturation.
module tb_branch_resolver;

    localparam int FLUSH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_offset = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic        in_pred_taken = 1'b0;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [2:0]  cmp_op;
    logic        cmp_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_taken;
    logic [31:0] out_target;
    logic [15:0] mispredict_count;

    branch_resolver #(.FLUSH_CYCLES(FLUSH)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_pc            (in_pc),
        .in_offset        (in_offset),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_op            (in_op),
        .in_pred_taken    (in_pred_taken),
        .cmp_a            (cmp_a),
        .cmp_b            (cmp_b),
        .cmp_op           (cmp_op),
        .cmp_out          (cmp_out),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_taken        (out_taken),
        .out_target       (out_target),
        .mispredict_count (mispredict_count)
    );

    always #5 clock = ~clock;

    // Stand-in for the external signed comparator.
    always_comb begin
        cmp_out = 1'b0;
        case (cmp_op)
            3'b000: cmp_out = (cmp_a == cmp_b);
            3'b001: cmp_out = ($signed(cmp_a) >= $signed(cmp_b));
            3'b010: cmp_out = ($signed(cmp_a) <= $signed(cmp_b));
            3'b011: cmp_out = ($signed(cmp_a) >  $signed(cmp_b));
            3'b100: cmp_out = ($signed(cmp_a) <  $signed(cmp_b));
            3'b101: cmp_out = (cmp_a != cmp_b);
            default: cmp_out = 1'b0;
        endcase
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] off;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        pred;
        logic        exp_taken;
        logic [31:0] exp_target;
        int          hold;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[9];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_mcount = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard side: every cycle with out_valid is compared against the head entry,
    // which is popped on the handshake.
    always @(negedge clock) begin
        if (reset) begin
            if (redirect_valid) begin
                if (sb_q.size() == 0) chk("redirect_unexpected", 32'(sb_q.size()), 1);
                else chk("redirect_pc", redirect_pc, sb_q[0].target);
            end
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("out_unexpected", 32'(sb_q.size()), 1);
                end else begin
                    chk("out_taken", 32'(out_taken), 32'(sb_q[0].taken));
                    chk("out_target", out_target, sb_q[0].target);
                    chk("in_ready_busy", 32'(in_ready), 0);
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic run_branch(input vec_t v);
        exp_t e;
        int   rc;
        int   fc;
        int   first_valid;
        int   hold_cnt;
        bit   done;
        e.taken  = v.exp_taken;
        e.target = v.exp_target;
        e.mis    = (v.exp_taken != v.pred);
        @(posedge clock); #1;
        chk($sformatf("in_ready_idle pc=%h", v.pc), 32'(in_ready), 1);
        in_pc = v.pc; in_offset = v.off; in_a = v.a; in_b = v.b;
        in_op = v.op; in_pred_taken = v.pred; in_valid = 1'b1;
        out_ready = (v.hold == 0);
        sb_q.push_back(e);
        @(posedge clock); #1;
        in_valid = 1'b0;
        rc = 0; fc = 0; first_valid = -1; hold_cnt = 0; done = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                chk($sformatf("cmp_a pc=%h", v.pc), cmp_a, v.a);
                chk($sformatf("cmp_b pc=%h", v.pc), cmp_b, v.b);
                chk($sformatf("cmp_op pc=%h", v.pc), 32'(cmp_op), 32'(v.op));
            end
            if (redirect_valid) rc++;
            if (flush) fc++;
            if (out_valid && first_valid < 0) begin
                first_valid = cyc;
                chk($sformatf("flush_with_redirect pc=%h", v.pc), 32'(flush), 32'(e.mis));
            end
            if (out_valid && out_ready) done = 1;
            else if (out_valid) hold_cnt++;
            if (!done) begin
                @(posedge clock); #1;
                if (hold_cnt >= v.hold) out_ready = 1'b1;
            end
        end
        chk($sformatf("transfer_done pc=%h", v.pc), 32'(done), 1);
        chk($sformatf("latency pc=%h", v.pc), first_valid, 2);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (k == 0) chk($sformatf("in_ready_after pc=%h", v.pc), 32'(in_ready), 1);
            if (!flush) break;
            fc++;
        end
        if (e.mis && exp_mcount != 16'hFFFF) exp_mcount = exp_mcount + 16'd1;
        chk($sformatf("redirect_pulses pc=%h", v.pc), rc, 32'(e.mis));
        chk($sformatf("flush_cycles pc=%h", v.pc), fc, e.mis ? FLUSH : 0);
        chk($sformatf("mispredict_count pc=%h", v.pc), 32'(mispredict_count), 32'(exp_mcount));
        $display("branch pc=%h op=%0d pred=%0d -> taken=%0d target=%h redirects=%0d flush=%0d count=%h",
                 v.pc, v.op, v.pred, out_taken, out_target, rc, fc, mispredict_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   rc;
        int   vc;

        vecs[0] = '{pc: 32'h100, off: 32'd3, a: 32'd5, b: 32'd5, op: 3'b000, pred: 1'b1,
                    exp_taken: 1'b1, exp_target: 32'h110, hold: 0};
        vecs[1] = '{pc: 32'h200, off: 32'd0, a: 32'd3, b: 32'd7, op: 3'b011, pred: 1'b1,
                    exp_taken: 1'b0, exp_target: 32'h204, hold: 0};
        vecs[2] = '{pc: 32'h300, off: 32'd8, a: 32'd1, b: 32'd2, op: 3'b100, pred: 1'b0,
                    exp_taken: 1'b1, exp_target: 32'h324, hold: 4};
        vecs[3] = '{pc: 32'hFFFFFFF8, off: 32'd1, a: 32'd1, b: 32'd2, op: 3'b101, pred: 1'b1,
                    exp_taken: 1'b1, exp_target: 32'h0, hold: 0};
        vecs[4] = '{pc: 32'h40, off: 32'hFFFFFFFE, a: 32'd9, b: 32'd9, op: 3'b001, pred: 1'b0,
                    exp_taken: 1'b1, exp_target: 32'h3C, hold: 0};
        vecs[5] = '{pc: 32'h500, off: 32'd4, a: 32'd0, b: 32'd0, op: 3'b111, pred: 1'b0,
                    exp_taken: 1'b0, exp_target: 32'h504, hold: 0};
        vecs[6] = '{pc: 32'h600, off: 32'd2, a: 32'd6, b: 32'd6, op: 3'b110, pred: 1'b1,
                    exp_taken: 1'b0, exp_target: 32'h604, hold: 0};
        vecs[7] = '{pc: 32'h700, off: 32'hFFFFFFFF, a: 32'hFFFFFFFD, b: 32'd2, op: 3'b010, pred: 1'b0,
                    exp_taken: 1'b1, exp_target: 32'h700, hold: 0};
        vecs[8] = '{pc: 32'h800, off: 32'h10, a: 32'd10, b: 32'hFFFFFFFF, op: 3'b011, pred: 1'b1,
                    exp_taken: 1'b1, exp_target: 32'h844, hold: 1};

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_taken", 32'(out_taken), 0);
        chk("reset out_target", out_target, 0);
        chk("reset redirect_valid", 32'(redirect_valid), 0);
        chk("reset redirect_pc", redirect_pc, 0);
        chk("reset flush", 32'(flush), 0);
        chk("reset cmp_a", cmp_a, 0);
        chk("reset cmp_b", cmp_b, 0);
        chk("reset cmp_op", 32'(cmp_op), 0);
        chk("reset mispredict_count", 32'(mispredict_count), 0);
        @(posedge clock); #1;
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_branch(vecs[i]);

        // Reset asserted during COMPARE of a mispredicting branch.
        rv = vecs[1];
        rv.pc = 32'h900;
        @(posedge clock); #1;
        in_pc = rv.pc; in_offset = rv.off; in_a = rv.a; in_b = rv.b;
        in_op = rv.op; in_pred_taken = rv.pred; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        sb_q.delete();
        exp_mcount = '0;
        @(negedge clock);
        chk("midreset in_ready", 32'(in_ready), 1);
        chk("midreset out_valid", 32'(out_valid), 0);
        chk("midreset flush", 32'(flush), 0);
        chk("midreset mispredict_count", 32'(mispredict_count), 0);
        rc = 0; vc = 0;
        for (int k = 0; k < 6; k++) begin
            if (redirect_valid) rc++;
            if (out_valid) vc++;
            @(negedge clock);
        end
        chk("midreset redirects", rc, 0);
        chk("midreset out_valid_cycles", vc, 0);
        $display("midreset pc=%h redirects=%0d valid_cycles=%0d", rv.pc, rc, vc);

        // Preload the counter just below saturation instead of replaying 65533 mispredicts.
        @(posedge clock); #1;
        force dut.mispredict_count_reg = 16'hFFFD;
        #1;
        release dut.mispredict_count_reg;
        exp_mcount = 16'hFFFD;
        for (int i = 0; i < 3; i++) run_branch(vecs[1]);
        run_branch(vecs[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Sequential branch-resolution stage that sits directly upstream and downstream of the 32-bit comparator in the execute path. It accepts one conditional branch from decode, drives the comparator's operand and op inputs from registers, samples the comparator result, computes the actual next PC, and checks it against the front-end prediction. On a mismatch it issues a one-cycle redirect and holds a multi-cycle flush. Each resolved branch is handed to writeback over a valid/ready handshake.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `flush` stays high after a mispredict; legal range 1–15.
- `clock` input 1: single clock; everything updates on its rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `in_valid` input 1: decode presents a branch.
- `in_ready` output 1: the block can accept a branch (high only in IDLE).
- `in_pc` input 32: PC of the branch.
- `in_offset` input 32: sign-extended word offset.
- `in_a`, `in_b` input 32: compare operands.
- `in_op` input 3: compare code (000 eq, 001 ge, 010 le, 011 gt, 100 lt, 101 ne; 110/111 never true).
- `in_pred_taken` input 1: front-end prediction.
- `cmp_a`, `cmp_b` output 32: registered operands driven to the comparator.
- `cmp_op` output 3: registered compare code driven to the comparator.
- `cmp_out` input 1: combinational comparator result.
- `redirect_valid` output 1: one-cycle pulse on a mispredict.
- `redirect_pc` output 32: correct next PC, valid while `redirect_valid` is high.
- `flush` output 1: squash the younger pipeline stages.
- `out_valid` output 1: resolved record is valid.
- `out_ready` input 1: writeback accepts the record.
- `out_taken` output 1: actual branch outcome.
- `out_target` output 32: actual next PC.
- `mispredict_count` output 16: saturating count of mispredicts.

## Operation
- FSM states: IDLE, COMPARE, RESOLVE, HOLD.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: register pc, offset, a, b, op and pred; go to COMPARE.
- **COMPARE**
  - `cmp_a`/`cmp_b`/`cmp_op` show the registered values.
  - At the clock edge: register `taken`=`cmp_out`; compute target; go to RESOLVE.
- **Target arithmetic**
  - taken: target = pc + 4 + (offset << 2); not taken: target = pc + 4.
  - 32-bit modulo; carries out of bit 31 are dropped (wrap-around).
- **RESOLVE**
  - `out_valid`=1.
  - Mispredict when `taken` != pred. `redirect_valid` pulses for exactly the first RESOLVE cycle with `redirect_pc`=target.
  - On a mispredict, the flush counter loads `FLUSH_CYCLES` and `mispredict_count` increments, saturating at 16'hFFFF.
  - If `out_ready`: go to IDLE; otherwise go to HOLD.
- **HOLD**
  - `out_valid`=1; `out_taken` and `out_target` stay stable; no second redirect is issued.
  - Go to IDLE when `out_ready` is high.
- **Flush counter**
  - Runs independently of the FSM; `flush`=(counter≠0); decrements by 1 per cycle.
  - The next branch can be accepted while flush is still counting down.
  - A new mispredict reloads the counter to `FLUSH_CYCLES`.
- **op 110/111**: the comparator returns 0, so the branch resolves as not-taken. No error is flagged.
- **Reset** (also when asserted mid-operation)
  - FSM returns to IDLE; all registers clear.
  - The in-flight branch is discarded with no redirect.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`=0, `out_taken`=0, `out_target`=0.
  - `redirect_valid`=0, `redirect_pc`=0.
  - `flush`=0, flush counter=0.
  - `cmp_a`=0, `cmp_b`=0, `cmp_op`=000.
  - `mispredict_count`=0.
- Accept at edge N: COMPARE during N+1; RESOLVE during N+2, when `out_valid`, `redirect_valid` and `redirect_pc` appear.
  - Input-to-result latency is 2 cycles; throughput is one branch per 3 cycles with `out_ready` held high.
- `flush` rises in the same cycle as `redirect_valid` and stays high for exactly `FLUSH_CYCLES` cycles.
- The handshake transfers when `out_valid` && `out_ready`. Outputs may not change while `out_valid`=1 and `out_ready`=0.
- `in_ready` is a registered function of state only (no combinational path from `in_valid`).
- The only combinational input path is `cmp_out`, which is sampled at the end of COMPARE.

## Test plan
- **Taken, predicted taken**: pc=0x100, offset=3, a=b=5, op=000, pred=1 → out_taken=1, out_target=0x110 at cycle +2; redirect_valid=0; count stays 0.
- **Mispredict not-taken**: pc=0x200, a=3, b=7, op=011 (gt), pred=1 → out_taken=0; redirect_valid pulses 1 cycle with redirect_pc=0x204; flush high for exactly 2 cycles; count=1.
- **Backpressure**: out_ready=0 for 4 cycles during a mispredicting branch → block stays in HOLD; in_ready=0; outputs stable; a single redirect pulse; transfer occurs on the cycle out_ready rises.
- **Wrap and negative offset**:
  - pc=0xFFFFFFF8, offset=1, op=101 with a≠b → target=0x00000000.
  - pc=0x40, offset=0xFFFFFFFE, taken → target=0x3C.
- **Saturation and invalid op**:
  - Preload via 65 535 mispredicts, then one more → count stays 0xFFFF.
  - op=111, pred=0 → not taken with no redirect.
- **Reset mid-operation**: assert reset in the COMPARE cycle of a mispredicting branch → next cycle in_ready=1, out_valid=0, no redirect_valid, flush=0.
